// File: rtl/snitch_shared_acc_xbar.sv
// Crossbar between CoreCount Snitch cores and UnitCount shared accelerator units.
// Handles address decode, per-core credits, local error responses and round-robin arbitration both ways.
module snitch_shared_acc_xbar #(
    parameter int unsigned CoreCount      = 4,
    parameter int unsigned UnitCount      = 2,
    parameter int unsigned IdWidth        = 5,
    parameter int unsigned DataWidth      = 64,
    parameter int unsigned MaxOutstanding = 4,
    parameter bit          CutReq         = 1'b1,
    localparam int unsigned LogCoreCount  = (CoreCount > 1) ? $clog2(CoreCount) : 1,
    localparam int unsigned ExtIdWidth    = IdWidth + LogCoreCount
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [CoreCount-1:0]                  core_qvalid_i,
    output logic [CoreCount-1:0]                  core_qready_o,
    input  logic [CoreCount-1:0][31:0]            core_qaddr_i,
    input  logic [CoreCount-1:0][IdWidth-1:0]     core_qid_i,
    input  logic [CoreCount-1:0][31:0]            core_qdata_op_i,
    input  logic [CoreCount-1:0][3*DataWidth-1:0] core_qargs_i,
    output logic [CoreCount-1:0]                  core_pvalid_o,
    input  logic [CoreCount-1:0]                  core_pready_i,
    output logic [CoreCount-1:0][IdWidth-1:0]     core_pid_o,
    output logic [CoreCount-1:0][DataWidth-1:0]   core_pdata_o,
    output logic [CoreCount-1:0]                  core_perror_o,
    output logic [UnitCount-1:0]                  unit_qvalid_o,
    input  logic [UnitCount-1:0]                  unit_qready_i,
    output logic [UnitCount-1:0][31:0]            unit_qaddr_o,
    output logic [UnitCount-1:0][ExtIdWidth-1:0]  unit_qid_o,
    output logic [UnitCount-1:0][31:0]            unit_qdata_op_o,
    output logic [UnitCount-1:0][3*DataWidth-1:0] unit_qargs_o,
    input  logic [UnitCount-1:0]                  unit_pvalid_i,
    output logic [UnitCount-1:0]                  unit_pready_o,
    input  logic [UnitCount-1:0][ExtIdWidth-1:0]  unit_pid_i,
    input  logic [UnitCount-1:0][DataWidth-1:0]   unit_pdata_i,
    input  logic [UnitCount-1:0]                  unit_perror_i,
    output logic [CoreCount-1:0][3:0]             outstanding_o
);

    localparam int unsigned LogUnitCount = (UnitCount > 1) ? $clog2(UnitCount) : 1;
    localparam int unsigned SrcCount     = UnitCount + 1;
    localparam int unsigned LogSrcCount  = $clog2(SrcCount);

    logic [CoreCount-1:0][3:0]              cnt_q, cnt_d;
    logic [CoreCount-1:0]                   eligible, mapped;
    logic [CoreCount-1:0][LogUnitCount-1:0] target;

    logic [UnitCount-1:0][CoreCount-1:0]    req;
    logic [UnitCount-1:0]                   arb_valid, arb_ready, arb_hs;
    logic [UnitCount-1:0][LogCoreCount-1:0] arb_idx;
    logic [UnitCount-1:0][31:0]             arb_addr, arb_op;
    logic [UnitCount-1:0][ExtIdWidth-1:0]   arb_id;
    logic [UnitCount-1:0][3*DataWidth-1:0]  arb_args;

    logic [UnitCount-1:0][LogCoreCount-1:0] qptr_q, qptr_d, qlock_idx_q, qlock_idx_d;
    logic [UnitCount-1:0]                   qlock_q, qlock_d;
    logic [UnitCount-1:0]                   sp_valid_q, sp_valid_d;
    logic [UnitCount-1:0][31:0]             sp_addr_q, sp_addr_d, sp_op_q, sp_op_d;
    logic [UnitCount-1:0][ExtIdWidth-1:0]   sp_id_q, sp_id_d;
    logic [UnitCount-1:0][3*DataWidth-1:0]  sp_args_q, sp_args_d;

    logic [CoreCount-1:0]                   err_valid_q, err_valid_d, err_push, err_pop;
    logic [CoreCount-1:0][IdWidth-1:0]      err_id_q, err_id_d;

    logic [UnitCount-1:0][LogCoreCount-1:0] dest;
    logic [CoreCount-1:0][SrcCount-1:0]     rsrc;
    logic [CoreCount-1:0]                   rgnt_valid, resp_hs;
    logic [CoreCount-1:0][LogSrcCount-1:0]  rgnt_idx;
    logic [CoreCount-1:0][LogSrcCount-1:0]  rptr_q, rptr_d, rlock_idx_q, rlock_idx_d;
    logic [CoreCount-1:0]                   rlock_q, rlock_d;

    always_comb begin
        for (int c = 0; c < CoreCount; c++) begin
            eligible[c] = 32'(cnt_q[c]) < MaxOutstanding;
            mapped[c]   = core_qaddr_i[c] < UnitCount;
            target[c]   = core_qaddr_i[c][LogUnitCount-1:0];
        end
    end

    // Request arbiters; a granted-but-stalled core keeps the grant so the payload cannot change.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        req       = '0;
        arb_valid = '0;
        arb_ready = '0;
        arb_hs    = '0;
        arb_idx   = '0;
        arb_addr  = '0;
        arb_op    = '0;
        arb_id    = '0;
        arb_args  = '0;
        for (int u = 0; u < UnitCount; u++) begin
            for (int c = 0; c < CoreCount; c++) begin
                req[u][c] = core_qvalid_i[c] && eligible[c] && mapped[c]
                            && (target[c] == LogUnitCount'(u));
            end
            if (qlock_q[u] && req[u][qlock_idx_q[u]]) begin
                arb_valid[u] = 1'b1;
                arb_idx[u]   = qlock_idx_q[u];
            end else begin
                for (int k = 0; k < CoreCount; k++) begin
                    idx = (int'(qptr_q[u]) + k) % CoreCount;
                    if (!arb_valid[u] && req[u][LogCoreCount'(idx)]) begin
                        arb_valid[u] = 1'b1;
                        arb_idx[u]   = LogCoreCount'(idx);
                    end
                end
            end
            arb_ready[u] = CutReq ? (!sp_valid_q[u] || unit_qready_i[u]) : unit_qready_i[u];
            arb_hs[u]    = arb_valid[u] && arb_ready[u];
            if (arb_valid[u]) begin
                arb_addr[u] = core_qaddr_i[arb_idx[u]];
                arb_op[u]   = core_qdata_op_i[arb_idx[u]];
                arb_args[u] = core_qargs_i[arb_idx[u]];
                arb_id[u]   = {arb_idx[u], core_qid_i[arb_idx[u]]};
            end
        end
    end

    // An occupied error register may still accept when it is being drained this same cycle.
    always_comb begin
        core_qready_o = '0;
        err_push      = '0;
        for (int c = 0; c < CoreCount; c++) begin
            if (mapped[c]) begin
                for (int u = 0; u < UnitCount; u++) begin
                    if (arb_hs[u] && (arb_idx[u] == LogCoreCount'(c))) begin
                        core_qready_o[c] = 1'b1;
                    end
                end
            end else begin
                core_qready_o[c] = core_qvalid_i[c] && eligible[c]
                                   && (!err_valid_q[c] || err_pop[c]);
                err_push[c]      = core_qready_o[c];
            end
        end
    end

    always_comb begin
        qptr_d      = qptr_q;
        qlock_d     = qlock_q;
        qlock_idx_d = qlock_idx_q;
        sp_valid_d  = sp_valid_q;
        sp_addr_d   = sp_addr_q;
        sp_op_d     = sp_op_q;
        sp_id_d     = sp_id_q;
        sp_args_d   = sp_args_q;
        for (int u = 0; u < UnitCount; u++) begin
            if (arb_hs[u]) begin
                qptr_d[u] = LogCoreCount'((int'(arb_idx[u]) + 1) % CoreCount);
            end
            qlock_d[u]     = arb_valid[u] && !arb_ready[u];
            qlock_idx_d[u] = arb_idx[u];
            if (arb_ready[u]) begin
                sp_valid_d[u] = arb_valid[u];
                if (arb_valid[u]) begin
                    sp_addr_d[u] = arb_addr[u];
                    sp_op_d[u]   = arb_op[u];
                    sp_id_d[u]   = arb_id[u];
                    sp_args_d[u] = arb_args[u];
                end
            end
        end
    end

    assign unit_qvalid_o   = CutReq ? sp_valid_q : arb_valid;
    assign unit_qaddr_o    = CutReq ? sp_addr_q  : arb_addr;
    assign unit_qid_o      = CutReq ? sp_id_q    : arb_id;
    assign unit_qdata_op_o = CutReq ? sp_op_q    : arb_op;
    assign unit_qargs_o    = CutReq ? sp_args_q  : arb_args;

    // Response arbiters per core; the error register is the last source index.
    always_comb begin
        int unsigned sidx;
        sidx          = 0;
        dest          = '0;
        rsrc          = '0;
        rgnt_valid    = '0;
        rgnt_idx      = '0;
        resp_hs       = '0;
        err_pop       = '0;
        core_pvalid_o = '0;
        core_pid_o    = '0;
        core_pdata_o  = '0;
        core_perror_o = '0;
        unit_pready_o = '0;
        for (int u = 0; u < UnitCount; u++) begin
            dest[u] = unit_pid_i[u][ExtIdWidth-1:IdWidth];
        end
        for (int c = 0; c < CoreCount; c++) begin
            for (int u = 0; u < UnitCount; u++) begin
                rsrc[c][u] = unit_pvalid_i[u] && (dest[u] == LogCoreCount'(c));
            end
            rsrc[c][UnitCount] = err_valid_q[c];
            if (rlock_q[c] && rsrc[c][rlock_idx_q[c]]) begin
                rgnt_valid[c] = 1'b1;
                rgnt_idx[c]   = rlock_idx_q[c];
            end else begin
                for (int k = 0; k < SrcCount; k++) begin
                    sidx = (int'(rptr_q[c]) + k) % SrcCount;
                    if (!rgnt_valid[c] && rsrc[c][LogSrcCount'(sidx)]) begin
                        rgnt_valid[c] = 1'b1;
                        rgnt_idx[c]   = LogSrcCount'(sidx);
                    end
                end
            end
            core_pvalid_o[c] = rgnt_valid[c];
            if (rgnt_valid[c] && (rgnt_idx[c] == LogSrcCount'(UnitCount))) begin
                core_pid_o[c]    = err_id_q[c];
                core_perror_o[c] = 1'b1;
            end
            for (int u = 0; u < UnitCount; u++) begin
                if (rgnt_valid[c] && (rgnt_idx[c] == LogSrcCount'(u))) begin
                    core_pid_o[c]    = unit_pid_i[u][IdWidth-1:0];
                    core_pdata_o[c]  = unit_pdata_i[u];
                    core_perror_o[c] = unit_perror_i[u];
                    unit_pready_o[u] = core_pready_i[c];
                end
            end
            resp_hs[c] = rgnt_valid[c] && core_pready_i[c];
            err_pop[c] = resp_hs[c] && (rgnt_idx[c] == LogSrcCount'(UnitCount));
        end
    end

    always_comb begin
        cnt_d       = cnt_q;
        err_valid_d = err_valid_q;
        err_id_d    = err_id_q;
        rptr_d      = rptr_q;
        rlock_d     = rlock_q;
        rlock_idx_d = rlock_idx_q;
        for (int c = 0; c < CoreCount; c++) begin
            if (core_qvalid_i[c] && core_qready_o[c] && !resp_hs[c]) begin
                cnt_d[c] = cnt_q[c] + 4'd1;
            end else if (!(core_qvalid_i[c] && core_qready_o[c]) && resp_hs[c]) begin
                cnt_d[c] = cnt_q[c] - 4'd1;
            end
            if (err_push[c]) begin
                err_valid_d[c] = 1'b1;
                err_id_d[c]    = core_qid_i[c];
            end else if (err_pop[c]) begin
                err_valid_d[c] = 1'b0;
            end
            if (resp_hs[c]) begin
                rptr_d[c] = LogSrcCount'((int'(rgnt_idx[c]) + 1) % SrcCount);
            end
            rlock_d[c]     = rgnt_valid[c] && !core_pready_i[c];
            rlock_idx_d[c] = rgnt_idx[c];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q       <= '0;
            qptr_q      <= '0;
            qlock_q     <= '0;
            qlock_idx_q <= '0;
            sp_valid_q  <= '0;
            sp_addr_q   <= '0;
            sp_op_q     <= '0;
            sp_id_q     <= '0;
            sp_args_q   <= '0;
            err_valid_q <= '0;
            err_id_q    <= '0;
            rptr_q      <= '0;
            rlock_q     <= '0;
            rlock_idx_q <= '0;
        end else begin
            cnt_q       <= cnt_d;
            qptr_q      <= qptr_d;
            qlock_q     <= qlock_d;
            qlock_idx_q <= qlock_idx_d;
            sp_valid_q  <= sp_valid_d;
            sp_addr_q   <= sp_addr_d;
            sp_op_q     <= sp_op_d;
            sp_id_q     <= sp_id_d;
            sp_args_q   <= sp_args_d;
            err_valid_q <= err_valid_d;
            err_id_q    <= err_id_d;
            rptr_q      <= rptr_d;
            rlock_q     <= rlock_d;
            rlock_idx_q <= rlock_idx_d;
        end
    end

    assign outstanding_o = cnt_q;

    // A unit response tagged for a core that does not exist would be silently lost.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int u = 0; u < UnitCount; u++) begin
                assert (!(unit_pvalid_i[u] && (32'(dest[u]) >= CoreCount)));
            end
        end
    end

endmodule
